multdiv_seq: RTL and testbench

MULTDIV_SEQ -- requirements
Module: multdiv_seq

---
 rtl/multdiv_pkg.sv | 22 ++
 rtl/md_iter_counter.sv | 36 +++
 rtl/multdiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_multdiv_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Holds the FSM encoding, the shared-adder opcodes and a two's-complement magnitude helper.
package multdiv_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    SIGN,
    DONE
  } state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_iter_counter.sv
// Iteration counter: counts enabled cycles 0..ITER-1 without wrapping.
// terminal goes high once the cycle at ITER-1 has been consumed; clear restarts it.
module md_iter_counter
  import multdiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      terminal <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      terminal <= 1'b0;
    end else if (enable && !terminal) begin
      if (count == LAST) begin
        terminal <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-2 Booth) and divide (restoring) over an external shared adder.
// Result after ITER+1 cycles (mult) or ITER+2 (div); no backpressure, any start pulse aborts and restarts.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_result
);

  state_t      state, state_n;
  logic [31:0] hi, lo, opnd;  // hi/lo hold remainder/quotient while dividing
  logic        qm1, neg_q, ovf_div;
  logic        cnt_clear, cnt_en, cnt_term;
  logic [1:0]  booth_pair;
  logic [31:0] r_sh, q_sh, b_hi;
  logic        r_ge, b_sign, sum_ovf;

  md_iter_counter #(.ITER(ITER)) u_iter_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_term)
  );

  assign booth_pair = {lo[0], qm1};
  assign r_sh       = {hi[30:0], lo[31]};
  assign q_sh       = {lo[30:0], 1'b0};
  assign r_ge       = (r_sh >= opnd);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_n;
      data_resultRDY <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n    = state;
    alu_opA    = '0;
    alu_opB    = '0;
    alu_opcode = ALU_ADD;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      MULT: begin
        if (cnt_term) begin
          state_n = DONE;
        end else begin
          cnt_en = 1'b1;
          if (booth_pair == 2'b01) begin
            alu_opA = hi;
            alu_opB = opnd;
          end else if (booth_pair == 2'b10) begin
            alu_opA    = hi;
            alu_opB    = opnd;
            alu_opcode = ALU_SUB;
          end
        end
      end
      DIV: begin
        if (opnd == '0) begin
          state_n = DONE;
        end else if (cnt_term) begin
          state_n = SIGN;
        end else begin
          cnt_en     = 1'b1;
          alu_opA    = r_sh;
          alu_opB    = opnd;
          alu_opcode = ALU_SUB;
        end
      end
      SIGN: begin
        alu_opB    = lo;
        alu_opcode = ALU_SUB;
        state_n    = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (ctrl_MULT || ctrl_DIV) begin
      state_n   = ctrl_MULT ? MULT : DIV;
      cnt_clear = 1'b1;
      cnt_en    = 1'b0;
    end
  end

  // The 32-bit adder can overflow on HI+-A; recover the true 33rd bit so the shift sign-extends correctly.
  always_comb begin
    b_hi    = hi;
    sum_ovf = 1'b0;
    if (booth_pair == 2'b01) begin
      b_hi    = alu_result;
      sum_ovf = (hi[31] == opnd[31]) && (alu_result[31] != hi[31]);
    end else if (booth_pair == 2'b10) begin
      b_hi    = alu_result;
      sum_ovf = (hi[31] != opnd[31]) && (alu_result[31] != hi[31]);
    end
    b_sign = b_hi[31] ^ sum_ovf;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi             <= '0;
      lo             <= '0;
      qm1            <= 1'b0;
      opnd           <= '0;
      neg_q          <= 1'b0;
      ovf_div        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      hi             <= '0;
      lo             <= data_operandB;
      qm1            <= 1'b0;
      opnd           <= data_operandA;
      neg_q          <= 1'b0;
      ovf_div        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      hi             <= '0;
      lo             <= abs32(data_operandA);
      qm1            <= 1'b0;
      opnd           <= abs32(data_operandB);
      neg_q          <= data_operandA[31] ^ data_operandB[31];
      ovf_div        <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        MULT: begin
          if (!cnt_term) begin
            hi  <= {b_sign, b_hi[31:1]};
            lo  <= {b_hi[0], lo[31:1]};
            qm1 <= lo[0];
          end else begin
            data_result    <= lo;
            data_exception <= (hi != {32{lo[31]}});
          end
        end
        DIV: begin
          if (opnd == '0) begin
            data_result    <= '0;
            data_exception <= 1'b1;
          end else if (!cnt_term) begin
            if (r_ge) begin
              hi <= alu_result;
              lo <= {lo[30:0], 1'b1};
            end else begin
              hi <= r_sh;
              lo <= q_sh;
            end
          end
        end
        SIGN: begin
          data_result    <= neg_q ? alu_result : lo;
          data_exception <= ovf_div;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomised self-checking bench for multdiv_seq against an arithmetic reference model.
// The shared adder is modelled combinationally here.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [31:0] alu_opA, alu_opB, alu_result;
  logic [4:0]  alu_opcode;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .alu_opA        (alu_opA),
    .alu_opB        (alu_opB),
    .alu_opcode     (alu_opcode),
    .alu_result     (alu_result)
  );

  always #5 clock = ~clock;

  assign alu_result = (alu_opcode == 5'b00001) ? (alu_opA - alu_opB) : (alu_opA + alu_opB);

  function automatic void mult_model(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic e);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    r = p[31:0];
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  function automatic void div_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    int q;
    if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  // Caller is at a negedge; returns at the negedge on which RDY is seen.
  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic exc, output bit timeout);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mult;
    ctrl_DIV      = !is_mult;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat     = 0;
    timeout = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (data_resultRDY) begin
        timeout = 1'b0;
        break;
      end
    end
    res = data_result;
    exc = data_exception;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++; if (data_result !== 32'd0) $display("FAIL reset_result got %h want 0", data_result); else n_pass++;
    n_checks++; if (data_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", data_exception); else n_pass++;
    n_checks++; if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b want 0", data_resultRDY); else n_pass++;
    n_checks++;
    if (alu_opA !== 32'd0 || alu_opB !== 32'd0 || alu_opcode !== 5'd0)
      $display("FAIL reset_alu got %h/%h/%b want 0/0/0", alu_opA, alu_opB, alu_opcode);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (data_resultRDY !== 1'b0) $display("FAIL idle_rdy got %b want 0", data_resultRDY); else n_pass++;
  endtask

  task automatic test_directed();
    int lat; logic [31:0] res; logic exc; bit to;
    run_op(1'b1, 32'd7, -32'sd3, lat, res, exc, to);
    n_checks++; if (to || lat != 33) $display("FAIL mul7x-3_latency got %0d want 33", lat); else n_pass++;
    n_checks++; if (res !== 32'hFFFF_FFEB) $display("FAIL mul7x-3_result got %h want ffffffeb", res); else n_pass++;
    n_checks++; if (exc !== 1'b0) $display("FAIL mul7x-3_exc got %b want 0", exc); else n_pass++;
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, lat, res, exc, to);
    n_checks++; if (to || res !== 32'd0) $display("FAIL mul_ovf_result got %h want 0", res); else n_pass++;
    n_checks++; if (exc !== 1'b1) $display("FAIL mul_ovf_exc got %b want 1", exc); else n_pass++;
    run_op(1'b0, -32'sd7, 32'd2, lat, res, exc, to);
    n_checks++; if (to || lat != 34) $display("FAIL div-7/2_latency got %0d want 34", lat); else n_pass++;
    n_checks++; if (res !== 32'hFFFF_FFFD) $display("FAIL div-7/2_result got %h want fffffffd", res); else n_pass++;
    n_checks++; if (exc !== 1'b0) $display("FAIL div-7/2_exc got %b want 0", exc); else n_pass++;
    run_op(1'b0, 32'd5, 32'd0, lat, res, exc, to);
    n_checks++; if (to || lat != 1) $display("FAIL div_by0_latency got %0d want 1", lat); else n_pass++;
    n_checks++; if (res !== 32'd0 || exc !== 1'b1) $display("FAIL div_by0_out got %h/%b want 0/1", res, exc); else n_pass++;
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, exc, to);
    n_checks++; if (to || lat != 34) $display("FAIL div_min_latency got %0d want 34", lat); else n_pass++;
    n_checks++; if (res !== 32'h8000_0000 || exc !== 1'b1) $display("FAIL div_min_out got %h/%b want 80000000/1", res, exc); else n_pass++;
  endtask

  task automatic test_mult_random();
    logic [31:0] specials [6];
    logic [31:0] a, b, er, res; logic ee, exc; int lat; bit to;
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
    for (int i = 0; i < 20; i++) begin
      a = (i % 3 == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = (i % 4 == 1) ? specials[$urandom_range(0, 5)] : ((i % 2 == 0) ? $urandom : $urandom_range(0, 2000) - 1000);
      mult_model(a, b, er, ee);
      run_op(1'b1, a, b, lat, res, exc, to);
      n_checks++;
      if (to || lat != 33 || res !== er || exc !== ee)
        $display("FAIL mult_rand[%0d] %h*%h got %h/%b lat %0d want %h/%b lat 33", i, a, b, res, exc, lat, er, ee);
      else n_pass++;
    end
  endtask

  task automatic test_div_random();
    logic [31:0] a, b, er, res; logic ee, exc; int lat, el; bit to;
    for (int i = 0; i < 20; i++) begin
      a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 300);
        2:       b = -$urandom_range(1, 300);
        default: b = (i == 7) ? 32'd0 : 32'hFFFF_FFFF;
      endcase
      div_model(a, b, er, ee);
      el = (b == 32'd0) ? 1 : 34;
      run_op(1'b0, a, b, lat, res, exc, to);
      n_checks++;
      if (to || lat != el || res !== er || exc !== ee)
        $display("FAIL div_rand[%0d] %h/%h got %h/%b lat %0d want %h/%b lat %0d", i, a, b, res, exc, lat, er, ee, el);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, pulses; logic [31:0] res; logic exc; bit to;
    data_operandA = 32'h0000_1234;
    data_operandB = 32'h5555_5555;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    // Iteration 10 sees {B[10],B[9]} = 10: subtract the multiplicand.
    n_checks++;
    if (alu_opcode !== 5'b00001 || alu_opB !== 32'h0000_1234)
      $display("FAIL mid_mult_alu got %b/%h want 00001/00001234", alu_opcode, alu_opB);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0)
      $display("FAIL async_reset_out got %h/%b/%b want 0/0/0", data_result, data_exception, data_resultRDY);
    else n_pass++;
    n_checks++;
    if (alu_opA !== 32'd0 || alu_opB !== 32'd0 || alu_opcode !== 5'd0)
      $display("FAIL async_reset_alu got %h/%h/%b want 0/0/0", alu_opA, alu_opB, alu_opcode);
    else n_pass++;
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    n_checks++; if (pulses != 0) $display("FAIL reset_discard got %0d pulses want 0", pulses); else n_pass++;
    run_op(1'b0, 32'd100, 32'd7, lat, res, exc, to);
    n_checks++;
    if (to || lat != 34 || res !== 32'd14 || exc !== 1'b0)
      $display("FAIL post_reset_div got %h/%b lat %0d want 0000000e/0 lat 34", res, exc, lat);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] a, b, er, res; logic ee, exc; int lat, pulses;
    for (int k = 0; k < 3; k++) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
      ctrl_MULT     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      repeat (5) @(negedge clock);
      a = $urandom;
      b = $urandom_range(1, 1000);
      if (k == 1) b = -b;
      div_model(a, b, er, ee);
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_DIV = 1'b0;
      pulses = 0;
      lat    = 0;
      res    = 'x;
      exc    = 1'bx;
      for (int i = 1; i <= 60; i++) begin
        @(negedge clock);
        if (data_resultRDY) begin
          if (pulses == 0) begin
            lat = i;
            res = data_result;
            exc = data_exception;
          end
          pulses++;
        end
      end
      n_checks++; if (pulses != 1) $display("FAIL abort[%0d]_pulses got %0d want 1", k, pulses); else n_pass++;
      n_checks++;
      if (lat != 34 || res !== er || exc !== ee)
        $display("FAIL abort[%0d]_div got %h/%b lat %0d want %h/%b lat 34", k, res, exc, lat, er, ee);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er, res; logic ee, exc; int lat; bit to;
    run_op(1'b1, 32'hFFFF_0001, 32'h0000_0300, lat, res, exc, to);
    mult_model(32'hFFFF_0001, 32'h0000_0300, er, ee);
    n_checks++; if (to || res !== er || exc !== ee) $display("FAIL b2b_mult got %h/%b want %h/%b", res, exc, er, ee); else n_pass++;
    // Restart issued during the DONE cycle.
    run_op(1'b0, 32'd1000, -32'sd9, lat, res, exc, to);
    n_checks++;
    if (to || lat != 34 || res !== 32'hFFFF_FF91 || exc !== 1'b0)
      $display("FAIL b2b_div got %h/%b lat %0d want ffffff91/0 lat 34", res, exc, lat);
    else n_pass++;
    @(negedge clock);
    n_checks++; if (data_resultRDY !== 1'b0) $display("FAIL rdy_single_pulse got %b want 0", data_resultRDY); else n_pass++;
    repeat (4) @(negedge clock);
    n_checks++;
    if (data_result !== 32'hFFFF_FF91 || data_exception !== 1'b0)
      $display("FAIL result_hold got %h/%b want ffffff91/0", data_result, data_exception);
    else n_pass++;
    n_checks++;
    if (alu_opA !== 32'd0 || alu_opB !== 32'd0 || alu_opcode !== 5'd0)
      $display("FAIL idle_alu got %h/%h/%b want 0/0/0", alu_opA, alu_opB, alu_opcode);
    else n_pass++;
  endtask

  task automatic test_priority();
    int lat; logic [31:0] res; bit to;
    data_operandA = 32'd7;
    data_operandB = -32'sd3;
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (data_resultRDY) begin
        to = 1'b0;
        break;
      end
    end
    res = data_result;
    n_checks++;
    if (to || lat != 33 || res !== 32'hFFFF_FFEB)
      $display("FAIL both_start_mult_wins got %h lat %0d want ffffffeb lat 33", res, lat);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mult_random();
    test_div_random();
    test_reset_mid_op();
    test_abort();
    test_back_to_back();
    test_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
